ultra_sonic_responder: RTL
==========================

ULTRA_SONIC_RESPONDER -- requirements
Module: ultra_sonic_responder

Interface
REQ-001 SHALL have parameter TRIG_MIN_CYCLES, default 500: minimum trigger high time (10 us at 50 MHz) for a valid ping.
REQ-002 SHALL have parameter ECHO_DELAY_CYCLES, default 1000: cycles from trigger fall to echo rise (burst latency).
REQ-003 SHALL have parameter ECHO_SHIFT, default 6: echo width in cycles = distance << ECHO_SHIFT.
REQ-004 SHALL have parameter NO_TARGET_CYCLES, default 1900000: echo width used when distance == 0 (no target).
REQ-005 SHALL have parameter HOLDOFF_CYCLES, default 3000000: post-echo dead time (60 ms).
REQ-006 SHALL have port clk, input, 1: single clock, 50 MHz; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port trigger, input, 1: ping request from the sensor driver, same clock domain.
REQ-009 SHALL have port cfg_distance, input, 16: simulated distance in echo units.
REQ-010 SHALL have port cfg_valid, input, 1: loads cfg_distance into the distance register.
REQ-011 SHALL have port echo, output, 1: emulated echo pulse.
REQ-012 SHALL have port busy, output, 1: high whenever state != IDLE.
REQ-013 SHALL have port short_trig, output, 1: one-cycle pulse on a rejected (too short) trigger.
REQ-014 SHALL have port echo_done, output, 1: one-cycle pulse in the first cycle after echo falls.
REQ-015 SHALL have port ping_count, output, 8: count of completed echoes.

Function
REQ-016 SHALL implement states IDLE, TRIG_HIGH, DELAY, ECHO and HOLDOFF; echo SHALL equal (state == ECHO) with no extra register stage.
REQ-017 IDLE -> TRIG_HIGH SHALL occur only on a rising edge (trigger == 1 and the previous-cycle trigger sample == 0); trig_count SHALL load 1.
REQ-018 In TRIG_HIGH, trig_count SHALL increment each cycle trigger samples 1 and SHALL saturate at TRIG_MIN_CYCLES.
REQ-019 In TRIG_HIGH with trigger == 0 and trig_count >= TRIG_MIN_CYCLES, the FSM SHALL go to DELAY and latch the distance register into a working register.
REQ-020 In TRIG_HIGH with trigger == 0 and trig_count < TRIG_MIN_CYCLES, the FSM SHALL go to IDLE and pulse short_trig for the next cycle.
REQ-021 DELAY SHALL last exactly ECHO_DELAY_CYCLES cycles; echo SHALL be high exactly ECHO_DELAY_CYCLES cycles after the first clock edge that samples trigger low.
REQ-022 ECHO SHALL last exactly W cycles: W = working << ECHO_SHIFT if working != 0, else NO_TARGET_CYCLES. Computation SHALL use a 24-bit counter with no truncation.
REQ-023 ECHO -> HOLDOFF: echo_done SHALL pulse and ping_count SHALL increment, wrapping 255 -> 0.
REQ-024 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles and then go to IDLE; trigger SHALL be ignored throughout DELAY, ECHO and HOLDOFF.
REQ-025 A trigger still high on entry to IDLE SHALL NOT start a ping; it SHALL wait for a new rising edge.
REQ-026 cfg_valid SHALL update the distance register in any state; the active ping's width SHALL depend only on the working register latched at REQ-019.
REQ-027 cfg_valid in the same cycle as the REQ-019 transition SHALL cause the old distance to be latched; the new value SHALL apply to the next ping.

Reset
REQ-028 reset SHALL force state IDLE, echo/busy/short_trig/echo_done 0, ping_count 0, all counters 0, distance and working registers 0, and the previous-trigger sample to 1.
REQ-029 reset asserted mid-ping SHALL drop echo on the next edge, with no echo_done pulse.

Verification (sim parameters TRIG_MIN=4, ECHO_DELAY=3, ECHO_SHIFT=2, NO_TARGET=20, HOLDOFF=5)
REQ-030 cfg_distance=5 loaded, then trigger high 4 cycles -> echo rises 3 cycles after trigger falls, stays high 20 cycles, echo_done pulses once, ping_count=1, busy low after 5 more cycles.
REQ-031 Trigger high for 3 cycles -> short_trig pulses once, echo stays low, FSM back in IDLE.
REQ-032 distance=0, valid trigger -> echo high 20 cycles (NO_TARGET).
REQ-033 Trigger re-pulsed during DELAY, ECHO and HOLDOFF; trigger held high across the return to IDLE -> single echo only; the next ping starts only after trigger goes low then high.
REQ-034 cfg_distance=2 loaded mid-echo of a distance=5 ping -> current echo 20 cycles, next echo 8 cycles.
REQ-035 256 valid pings -> ping_count wraps to 0; reset asserted mid-ECHO -> echo 0 on the next edge, ping_count 0.

Source files
------------

// File: rtl/ultra_sonic_responder.sv
// rtl/ultra_sonic_responder.sv - ultrasonic range sensor emulator: trigger qualification, delayed echo, holdoff
// Echo width is the latched distance scaled by ECHO_SHIFT, or a fixed no-target width for zero distance.
module ultra_sonic_responder #(
    parameter int TRIG_MIN_CYCLES   = 500,
    parameter int ECHO_DELAY_CYCLES = 1000,
    parameter int ECHO_SHIFT        = 6,
    parameter int NO_TARGET_CYCLES  = 1900000,
    parameter int HOLDOFF_CYCLES    = 3000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] cfg_distance,
    input  logic        cfg_valid,
    output logic        echo,
    output logic        busy,
    output logic        short_trig,
    output logic        echo_done,
    output logic [7:0]  ping_count
);

    typedef enum logic [2:0] {IDLE, TRIG_HIGH, DELAY, ECHO, HOLDOFF} state_t;

    localparam logic [23:0] TRIG_MIN   = 24'(TRIG_MIN_CYCLES);
    localparam logic [23:0] DELAY_LAST = 24'(ECHO_DELAY_CYCLES - 1);
    localparam logic [23:0] HOLD_LAST  = 24'(HOLDOFF_CYCLES - 1);
    localparam logic [23:0] NO_TARGET  = 24'(NO_TARGET_CYCLES);

    state_t      state;
    logic [23:0] trig_count;
    logic [23:0] phase_count;
    logic [23:0] echo_width;
    logic [15:0] distance;
    logic [15:0] working;
    logic        trig_prev;

    // Widened to 24 bits before shifting so large distances are not truncated.
    always_comb begin
        echo_width = NO_TARGET;
        if (working != 16'd0) begin
            echo_width = {8'd0, working} << ECHO_SHIFT;
        end
    end

    assign echo = (state == ECHO);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            trig_count  <= '0;
            phase_count <= '0;
            distance    <= '0;
            working     <= '0;
            trig_prev   <= 1'b1;
            short_trig  <= 1'b0;
            echo_done   <= 1'b0;
            ping_count  <= '0;
        end else begin
            trig_prev  <= trigger;
            short_trig <= 1'b0;
            echo_done  <= 1'b0;
            if (cfg_valid) begin
                distance <= cfg_distance;
            end
            case (state)
                IDLE: begin
                    // Prev sample starts at 1 so a trigger held across reset/holdoff needs a fresh edge.
                    if (trigger && !trig_prev) begin
                        state      <= TRIG_HIGH;
                        trig_count <= 24'd1;
                    end
                end
                TRIG_HIGH: begin
                    if (trigger) begin
                        if (trig_count < TRIG_MIN) begin
                            trig_count <= trig_count + 24'd1;
                        end
                    end else begin
                        trig_count <= '0;
                        if (trig_count >= TRIG_MIN) begin
                            state       <= DELAY;
                            working     <= distance;
                            phase_count <= '0;
                        end else begin
                            state      <= IDLE;
                            short_trig <= 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (phase_count == DELAY_LAST) begin
                        state       <= ECHO;
                        phase_count <= '0;
                    end else begin
                        phase_count <= phase_count + 24'd1;
                    end
                end
                ECHO: begin
                    if (phase_count == echo_width - 24'd1) begin
                        state       <= HOLDOFF;
                        phase_count <= '0;
                        echo_done   <= 1'b1;
                        ping_count  <= ping_count + 8'd1;
                    end else begin
                        phase_count <= phase_count + 24'd1;
                    end
                end
                HOLDOFF: begin
                    if (phase_count == HOLD_LAST) begin
                        state       <= IDLE;
                        phase_count <= '0;
                    end else begin
                        phase_count <= phase_count + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
